kyber_compress_stream: RTL and testbench

KYBER_COMPRESS_STREAM -- requirements
Module: kyber_compress_stream

---
 rtl/kyber_compress_stream.sv | 183 ++++++++++++++++++
 tb/tb_kyber_compress_stream.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_compress_stream.sv
// kyber_compress_stream
// Streaming Kyber Compress_q / Decompress_q engine with a 2-stage pipeline.
// Each polynomial is N beats. The bit count d and the mode are captured on the
// first beat of a polynomial and apply to all N beats of it.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block can take a beat this cycle
//   in_data    coefficient x (compress) or code y (decompress)
//   in_d       bit count d (legal 1..D_MAX), used only on the first beat
//   in_mode    0 = compress, 1 = decompress, used only on the first beat
//   out_valid  output beat valid
//   out_ready  sink takes the beat this cycle
//   out_data   result, zero-extended to W
//   out_last   marks the Nth output beat of a polynomial
//   out_err    per-beat error (x >= Q in compress mode, or illegal d)
//   err        sticky error; set by any transferred out_err beat
//   err_clr    synchronous clear of err (a set in the same cycle wins)
//   busy       polynomial partially accepted or pipeline occupied
//
// Handshake: a beat moves on a rising edge exactly when valid and ready are
// both high on that edge. A source holding valid keeps its payload stable
// until the transfer. in_ready does not depend on in_valid. out_valid and
// the output payload stay stable until out_ready is seen.
module kyber_compress_stream #(
    parameter int Q     = 3329,
    parameter int N     = 256,
    parameter int W     = 16,
    parameter int D_MAX = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [3:0]   in_d,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         out_err,
    output logic         err,
    input  logic         err_clr,
    output logic         busy
);

    // x * 2^D_MAX + Q/2 for x = 2^W-1 needs W + D_MAX + 1 bits.
    localparam int NUM_W = W + D_MAX + 1;
    localparam int Q_W   = $clog2(Q);
    // With K = NUM_W + Q_W and M = ceil(2^K / Q), floor(n*M / 2^K) equals
    // floor(n / Q) for every n < 2^NUM_W. Therefore the divide is exact over
    // the full input range.
    localparam int K     = NUM_W + Q_W;
    localparam int M_W   = K - Q_W + 1;
    localparam int P_W   = NUM_W + M_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [M_W-1:0]   RECIP   = M_W'(((64'd1 << K) + 64'(Q) - 64'd1) / 64'(Q));
    localparam logic [NUM_W-1:0] HALF_Q  = NUM_W'(Q / 2);
    localparam logic [NUM_W-1:0] Q_EXT   = NUM_W'(Q);
    localparam logic [W-1:0]     Q_IN    = W'(Q);
    localparam logic [3:0]       D_MAX_4 = 4'(D_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);

    logic             adv;
    logic             accept;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       lat_d;
    logic             lat_mode;

    logic [3:0]       eff_d;
    logic             eff_mode;
    logic             eff_d_ok;
    logic [W-1:0]     y_mask;
    logic [NUM_W-1:0] x_ext;
    logic [NUM_W-1:0] y_ext;
    logic [NUM_W-1:0] comp_num;
    logic [NUM_W-1:0] dec_num;
    logic             beat_err;

    logic             s1_valid;
    logic [NUM_W-1:0] s1_num;
    logic [3:0]       s1_d;
    logic             s1_mode;
    logic             s1_d_ok;
    logic             s1_last;
    logic             s1_err;

    logic [P_W-1:0]   prod;
    logic [W-1:0]     quot;
    logic [W-1:0]     comp_res;
    logic [W-1:0]     dec_res;
    logic [W-1:0]     s2_res;

    // The whole pipeline moves forward unless the output beat is blocked.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = rst && adv;
    assign accept   = in_valid && in_ready;
    assign busy     = (cnt != '0) || s1_valid || out_valid;

    // The first beat of a polynomial uses its own d/mode. Later beats use
    // the values captured with the first beat.
    assign eff_d    = (cnt == '0) ? in_d    : lat_d;
    assign eff_mode = (cnt == '0) ? in_mode : lat_mode;
    assign eff_d_ok = (eff_d != 4'd0) && (eff_d <= D_MAX_4);

    // Stage 1: multiply / add.
    always_comb begin
        y_mask   = in_data & ((W'(1) << eff_d) - W'(1));
        x_ext    = {{(NUM_W-W){1'b0}}, in_data};
        y_ext    = {{(NUM_W-W){1'b0}}, y_mask};
        comp_num = (x_ext << eff_d) + HALF_Q;
        dec_num  = y_ext * Q_EXT + ((NUM_W'(1) << eff_d) >> 1);
        beat_err = !eff_d_ok || (!eff_mode && (in_data >= Q_IN));
    end

    // Stage 2: divide by Q using the reciprocal, then mask. Decompress only
    // needs the rounding shift.
    always_comb begin
        prod     = P_W'(s1_num) * P_W'(RECIP);
        quot     = W'(prod >> K);
        comp_res = quot & ((W'(1) << s1_d) - W'(1));
        dec_res  = W'(s1_num >> s1_d);
        s2_res   = '0;
        if (s1_d_ok)
            s2_res = s1_mode ? dec_res : comp_res;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            lat_d     <= '0;
            lat_mode  <= 1'b0;
            s1_valid  <= 1'b0;
            s1_num    <= '0;
            s1_d      <= '0;
            s1_mode   <= 1'b0;
            s1_d_ok   <= 1'b0;
            s1_last   <= 1'b0;
            s1_err    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
                if (cnt == '0) begin
                    lat_d    <= in_d;
                    lat_mode <= in_mode;
                end
            end

            if (adv) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_num  <= eff_mode ? dec_num : comp_num;
                    s1_d    <= eff_d;
                    s1_mode <= eff_mode;
                    s1_d_ok <= eff_d_ok;
                    s1_last <= (cnt == CNT_MAX);
                    s1_err  <= beat_err;
                end
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= s2_res;
                    out_last <= s1_last;
                    out_err  <= s1_err;
                end
            end

            if (out_valid && out_ready && out_err)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kyber_compress_stream.sv
// tb_kyber_compress_stream
// Directed and random stream stimulus for kyber_compress_stream. A reference
// model is written straight from the Compress/Decompress formulas. Its
// expected beats go into a queue on acceptance and are popped as the DUT
// emits them.
module tb_kyber_compress_stream;

    localparam int Q     = 3329;
    localparam int N     = 256;
    localparam int W     = 16;
    localparam int D_MAX = 12;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic [3:0]   in_d      = '0;
    logic         in_mode   = 1'b0;
    logic         out_ready = 1'b0;
    logic         err_clr   = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_err;
    logic         err;
    logic         busy;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    // Scoreboard entry: {err, last, data}.
    logic [W+1:0] exp_q[$];
    int           tb_cnt   = 0;
    logic [3:0]   tb_d     = '0;
    logic         tb_mode  = 1'b0;
    bit           rand_rdy = 1'b0;
    bit           hold_pend = 1'b0;
    logic [W+1:0] held     = '0;

    kyber_compress_stream #(.Q(Q), .N(N), .W(W), .D_MAX(D_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_d      (in_d),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_err   (out_err),
        .err       (err),
        .err_clr   (err_clr),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    // ---------------- check helper ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [3:0] d,
                                           input logic m, input logic last);
        longint num;
        longint r;
        logic   e;
        if (d == 4'd0 || int'(d) > D_MAX)
            return {1'b1, last, {W{1'b0}}};
        if (!m) begin
            num = longint'(x) * (longint'(1) << d) + longint'(Q / 2);
            r   = (num / longint'(Q)) % (longint'(1) << d);
            e   = (int'(x) >= Q);
        end else begin
            num = longint'(x) % (longint'(1) << d);
            r   = (num * longint'(Q) + (longint'(1) << (d - 1))) >> d;
            e   = 1'b0;
        end
        return {e, last, r[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rand_x(input logic m);
        if (m)
            return W'($urandom_range(0, 65535));
        if ($urandom_range(0, 15) == 0)
            return {W{1'b1}};
        return W'($urandom_range(0, 3400));
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a rising edge. It returns just after the edge on
    // which the beat was accepted.
    task automatic send_beat(input logic [W-1:0] x, input logic [3:0] d, input logic m);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = x;
        in_d     = d;
        in_mode  = m;
        @(negedge clk);
        while (!in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (tb_cnt == 0) begin
            tb_d    = d;
            tb_mode = m;
        end
        exp_q.push_back(model(x, tb_d, tb_mode, tb_cnt == N - 1));
        tb_cnt = (tb_cnt == N - 1) ? 0 : tb_cnt + 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input int n, input logic [3:0] d, input logic m);
        for (int i = 0; i < n; i++)
            send_beat(rand_x(m), d, m);
    endtask

    task automatic drain();
        int i = 0;
        while ((exp_q.size() != 0 || out_valid) && i < 3000) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Random backpressure on the sink side.
    initial forever begin
        @(posedge clk);
        #2;
        if (rand_rdy)
            out_ready = ($urandom_range(0, 2) != 0);
    end

    // ---------------- scoreboard / monitor ----------------
    initial forever begin
        logic [W+1:0] e;
        @(negedge clk);
        if (rst && out_valid) begin
            if (hold_pend) begin
                chk("stall_hold_data", 32'(out_data), 32'(held[W-1:0]));
                chk("stall_hold_last", 32'(out_last), 32'(held[W]));
                chk("stall_hold_err",  32'(out_err),  32'(held[W+1]));
            end
            if (out_ready) begin
                hold_pend = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(out_data), 32'(e[W-1:0]));
                    chk("beat_last", 32'(out_last), 32'(e[W]));
                    chk("beat_err",  32'(out_err),  32'(e[W+1]));
                end
            end else begin
                hold_pend = 1'b1;
                held      = {out_err, out_last, out_data};
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        #3;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_release", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // Poly A: compress d=11, first x=3331 (>= Q), fixed 2-cycle latency.
        send_beat(16'd3331, 4'd11, 1'b0);
        chk("latency_cycle1_valid", 32'(out_valid), 32'd0);
        chk("busy_mid_poly",        32'(busy),      32'd1);
        @(posedge clk);
        #1;
        chk("latency_cycle2_valid", 32'(out_valid), 32'd1);
        chk("latency_cycle2_data",  32'(out_data),  32'd1);
        chk("latency_cycle2_err",   32'(out_err),   32'd1);
        send_rand(255, 4'd11, 1'b0);
        drain();
        chk("idle_busy",  32'(busy), 32'd0);
        chk("err_sticky", 32'(err),  32'd1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);

        // Poly B: compress d=10 with known points, random backpressure.
        rand_rdy = 1'b1;
        send_beat(16'd0,    4'd10, 1'b0);
        send_beat(16'd1664, 4'd10, 1'b0);
        send_beat(16'd3328, 4'd10, 1'b0);
        send_rand(253, 4'd10, 1'b0);
        drain();

        // Poly C: decompress d=10, first y=512.
        send_beat(16'd512, 4'd10, 1'b1);
        send_rand(255, 4'd10, 1'b1);
        drain();

        // Poly D: d=4; in_d/in_mode change halfway and must be ignored.
        // Poly E: the new d=5 takes effect.
        send_beat(rand_x(1'b0), 4'd4, 1'b0);
        send_rand(127, 4'd4, 1'b0);
        send_rand(128, 4'd5, 1'b1);
        send_rand(256, 4'd5, 1'b0);
        drain();

        // Poly F: d=0, every beat is an error; clear colliding with a set.
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_rand(256, 4'd0, 1'b0);
        err_clr = 1'b1;
        chk("collide_beat_valid", 32'(out_valid), 32'd1);
        chk("collide_beat_err",   32'(out_err),   32'd1);
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("err_set_beats_clear", 32'(err), 32'd1);
        drain();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("err_clear_alone", 32'(err), 32'd0);

        // Poly G: reset at beat 100 with the pipeline full.
        send_beat(16'd4000, 4'd6, 1'b0);
        send_rand(99, 4'd6, 1'b0);
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        chk("pre_reset_busy",      32'(busy),      32'd1);
        chk("pre_reset_err",       32'(err),       32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data",  32'(out_data),  32'd0);
        chk("midrst_out_last",  32'(out_last),  32'd0);
        chk("midrst_out_err",   32'(out_err),   32'd0);
        chk("midrst_err",       32'(err),       32'd0);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd0);
        exp_q.delete();
        tb_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Poly H: fresh count after reset, d = D_MAX, random backpressure.
        rand_rdy = 1'b1;
        send_rand(256, 4'd12, 1'b0);
        drain();
        chk("post_poly_busy", 32'(busy), 32'd0);

        // Poly I: d above D_MAX, so every beat is zero with an error.
        send_rand(256, 4'd13, 1'b1);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
